// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word reads to instruction memory,
// presents fetched instructions to decode and computes the next PC on hand-off.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Inst_code,
  output logic [31:0] PC_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  PC_s,
  input  logic [25:0] address_J,
  input  logic [15:0] branch_imm,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

  // Last WAIT cycle index before a missing ack is declared a timeout.
  localparam logic [15:0] TimerLast = 16'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic        req_q;
  logic        fault_q;
  logic [15:0] timer_q;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        next_misaligned;

  // Next-PC select; relative targets are based on the instruction being handed off.
  always_comb begin
    pc_plus4   = pc_out_q + 32'd4;
    branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    next_pc    = pc_plus4;
    unique case (PC_s)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
      2'b10: next_pc = jr_target;
      2'b11: next_pc = {pc_plus4[31:28], address_J, 2'b00};
      default: next_pc = pc_plus4;
    endcase
    next_misaligned = (next_pc[1:0] != 2'b00);
  end

  // Fetch FSM with all outputs registered; acks are only honoured in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      inst_q   <= 32'd0;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      fault_q  <= 1'b0;
      timer_q  <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          timer_q <= 16'd0;
          if (imem_ack) begin
            inst_q   <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StHold;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_ack) begin
            inst_q   <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StHold;
          end else if (timer_q == TimerLast) begin
            fault_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StFault;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StHold: begin
          if (inst_ready) begin
            valid_q <= 1'b0;
            if (next_misaligned) begin
              // PC stays frozen at the last good fetch address.
              fault_q <= 1'b1;
              state_q <= StFault;
            end else begin
              pc_q    <= next_pc;
              req_q   <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        StFault: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Inst_code   = inst_q;
  assign PC_out      = pc_out_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: table of next-PC vectors plus hand-written
// sequences for reset, stall, timeout and misaligned-jump behaviour.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Inst_code;
  logic [31:0] PC_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  PC_s;
  logic [25:0] address_J;
  logic [15:0] branch_imm;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .Inst_code   (Inst_code),
    .PC_out      (PC_out),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .PC_s        (PC_s),
    .address_J   (address_J),
    .branch_imm  (branch_imm),
    .branch_taken(branch_taken),
    .jr_target   (jr_target),
    .fetch_fault (fetch_fault)
  );

  typedef struct {
    logic [31:0] pc_out;
    logic [1:0]  pc_s;
    logic [25:0] addr_j;
    logic [15:0] bimm;
    logic        btaken;
    logic [31:0] jr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a request, then ack after 'delay' cycles without ack.
  task automatic do_fetch(input int delay, input logic [31:0] data);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    repeat (delay) step();
    imem_rdata = data;
    imem_ack   = 1'b1;
    step();
    imem_ack   = 1'b0;
    chk("fetch_valid", {31'd0, inst_valid}, 32'd1);
    chk("fetch_inst", Inst_code, data);
  endtask

  // Hand off the held instruction with the given next-PC controls.
  task automatic consume(input logic [1:0] s, input logic [25:0] aj, input logic [15:0] bi,
                         input logic bt, input logic [31:0] jr);
    PC_s         = s;
    address_J    = aj;
    branch_imm   = bi;
    branch_taken = bt;
    jr_target    = jr;
    inst_ready   = 1'b1;
    step();
    inst_ready   = 1'b0;
    PC_s         = 2'b00;
    jr_target    = 32'hDEAD_BEE3;
    chk("valid_cleared", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_inst"}, Inst_code, 32'd0);
    chk({tag, "_pcout"}, PC_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0040_0010, 2'b11, 26'h010_0008, 16'h0000, 1'b0, 32'h0, 32'h0040_0020};
    vecs[1] = '{32'h0000_0100, 2'b01, 26'h0, 16'hFFFC, 1'b1, 32'h0, 32'h0000_00F4};
    vecs[2] = '{32'h0000_0100, 2'b01, 26'h0, 16'hFFFC, 1'b0, 32'h0, 32'h0000_0104};
    vecs[3] = '{32'hFFFF_FFFC, 2'b00, 26'h0, 16'h0000, 1'b0, 32'h0, 32'h0000_0000};
    vecs[4] = '{32'h0000_1000, 2'b01, 26'h0, 16'h0010, 1'b1, 32'h0, 32'h0000_1044};
    vecs[5] = '{32'hA000_0000, 2'b11, 26'h3FF_FFFF, 16'h0000, 1'b0, 32'h0, 32'hAFFF_FFFC};
    vecs[6] = '{32'h0000_0000, 2'b01, 26'h0, 16'h8000, 1'b1, 32'h0, 32'hFFFE_0004};
    vecs[7] = '{32'h0000_0020, 2'b10, 26'h0, 16'h0000, 1'b0, 32'h1234_5678, 32'h1234_5678};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    PC_s = 2'b00; address_J = 26'h0; branch_imm = 16'h0; branch_taken = 1'b0;
    jr_target = 32'h0;

    // Reset values, then an ack during the IDLE cycle must be ignored.
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    imem_rdata = 32'hBAD0_0001;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, imem_req}, 32'd1);
    chk("idle_ack_valid", {31'd0, inst_valid}, 32'd0);

    // First fetch: ack on the second WAIT cycle.
    do_fetch(2, 32'h2008_0005);
    chk("first_pcout", PC_out, 32'd0);
    chk("first_req_low", {31'd0, imem_req}, 32'd0);
    consume(2'b00, 26'h0, 16'h0, 1'b0, 32'h0);
    chk("first_next_addr", imem_addr, 32'd4);
    chk("first_next_req", {31'd0, imem_req}, 32'd1);

    // HOLD stall with a stray ack: nothing may change.
    do_fetch(0, 32'h1111_2222);
    chk("stall_pcout0", PC_out, 32'd4);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'h9999_9999;
      imem_ack   = (i == 2);
      step();
      imem_ack = 1'b0;
      chk("stall_inst", Inst_code, 32'h1111_2222);
      chk("stall_pcout", PC_out, 32'd4);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    end
    consume(2'b00, 26'h0, 16'h0, 1'b0, 32'h0);
    chk("stall_next_addr", imem_addr, 32'd8);

    // Next-PC vectors: jump to the vector's PC, fetch it, then apply the select.
    for (int v = 0; v < 8; v++) begin
      do_fetch(1, 32'h0A00_0000 + 32'(v));
      consume(2'b10, 26'h0, 16'h0, 1'b0, vecs[v].pc_out);
      chk("vec_jump_addr", imem_addr, vecs[v].pc_out);
      do_fetch(0, 32'h0B00_0000 + 32'(v));
      chk("vec_pcout", PC_out, vecs[v].pc_out);
      consume(vecs[v].pc_s, vecs[v].addr_j, vecs[v].bimm, vecs[v].btaken, vecs[v].jr);
      chk("vec_next_addr", imem_addr, vecs[v].exp_next);
      chk("vec_next_req", {31'd0, imem_req}, 32'd1);
    end

    // Reset while waiting for an ack.
    step();
    step();
    chk("midwait_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    step();
    chk_reset_outputs("midwait_rst");
    rst = 1'b0;

    // Timeout: 16 WAIT cycles without ack.
    begin
      int n = 0;
      while (!imem_req && n < 20) begin
        step();
        n++;
      end
      chk("to_req_seen", {31'd0, imem_req}, 32'd1);
    end
    repeat (16) step();
    chk("to_not_yet", {31'd0, fetch_fault}, 32'd0);
    chk("to_req_still", {31'd0, imem_req}, 32'd1);
    step();
    chk("to_fault", {31'd0, fetch_fault}, 32'd1);
    chk("to_req_low", {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'h7777_7777;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    chk("to_ack_ignored", {31'd0, inst_valid}, 32'd0);
    chk("to_sticky", {31'd0, fetch_fault}, 32'd1);

    // Misaligned register jump.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mis_rst_fault", {31'd0, fetch_fault}, 32'd0);
    do_fetch(0, 32'h0000_0008);
    PC_s = 2'b10; jr_target = 32'h0000_0102; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    repeat (3) step();
    chk("mis_req_later", {31'd0, imem_req}, 32'd0);
    chk("mis_pc_frozen", imem_addr, 32'd0);
    chk("mis_sticky", {31'd0, fetch_fault}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
